// File: rtl/inst_issue_pkg.sv
// Shared types for the instruction issue controller.
//   state_e      : controller phase (IDLE, RUN, DRAIN, DONE)
//   NOP_INST_DEF : default bubble word, addi x0,x0,0
//   inst_t       : 32-bit instruction word
//   fifo_entry_t : one FIFO slot, end-of-program flag plus the word
package inst_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef logic [31:0] inst_t;

  typedef struct packed {
    logic  last;
    inst_t inst;
  } fifo_entry_t;

endpackage

// File: rtl/inst_issue_ctrl_sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through read.
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   push_i, din_i    : write strobe and data (ignored when full)
//   pop_i, dout_o    : read strobe; dout_o shows the head entry
//   full_o, empty_o  : occupancy flags
// DEPTH must be a power of two and at least 2.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit distinguishes full from empty when the
  // address bits coincide.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  // Reading the head from storage means a word written at one edge is
  // visible only after that edge: no bypass path.
  assign dout_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/inst_issue_ctrl.sv
// inst_issue_ctrl: buffers loader words and issues them to the core.
//   i_load_*/o_load_ready : loader push handshake into the FIFO
//   i_start               : starts a program run from IDLE or DONE
//   i_cpu_stall           : holds the current instruction and all counters
//   o_cpu_start/o_cpu_inst: registered core enable and instruction
//   i_ecall_*/o_ecall_*   : one-cycle registered copy of the core ecall strobe
//   o_busy/o_done         : RUN or DRAIN / DONE status
//   o_issue_cnt           : real words issued since the last start
// Underflow in RUN issues NOP_INST; after the last word, DRAIN_CYCLES
// unstalled NOPs are issued before DONE. DRAIN_CYCLES must be >= 1.
module inst_issue_ctrl
  import inst_issue_pkg::*;
#(
  parameter int          DEPTH        = 16,
  parameter logic [31:0] NOP_INST     = NOP_INST_DEF,
  parameter int          DRAIN_CYCLES = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_load_valid,
  input  logic [31:0] i_load_inst,
  input  logic        i_load_last,
  output logic        o_load_ready,
  input  logic        i_cpu_stall,
  output logic        o_cpu_start,
  output logic [31:0] o_cpu_inst,
  input  logic        i_ecall_ready,
  input  logic [31:0] i_ecall_data,
  output logic        o_ecall_valid,
  output logic [31:0] o_ecall_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_issue_cnt
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_e      state_q;
  logic        cpu_start_q;
  inst_t       cpu_inst_q;
  logic [31:0] issue_cnt_q;
  logic [DW-1:0] drain_cnt_q;
  logic        ecall_valid_q;
  logic [31:0] ecall_data_q;

  fifo_entry_t push_entry;
  fifo_entry_t pop_entry;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;

  assign push_entry = '{last: i_load_last, inst: i_load_inst};
  // Ready is purely !full, so a pop while full never admits a push.
  assign fifo_push  = i_load_valid && !fifo_full;
  assign fifo_pop   = (state_q == ST_RUN) && !i_cpu_stall && !fifo_empty;

  sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (push_entry),
    .dout_o  (pop_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cpu_start_q <= 1'b0;
      cpu_inst_q  <= '0;
      issue_cnt_q <= '0;
      drain_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // The core output is already 0 here; only start acts.
          if (i_start) begin
            state_q     <= ST_RUN;
            issue_cnt_q <= '0;
            cpu_start_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!i_cpu_stall) begin
            if (!fifo_empty) begin
              cpu_inst_q  <= pop_entry.inst;
              issue_cnt_q <= issue_cnt_q + 32'd1;
              if (pop_entry.last) begin
                state_q     <= ST_DRAIN;
                drain_cnt_q <= '0;
              end
            end else begin
              cpu_inst_q <= NOP_INST;
            end
          end
        end
        ST_DRAIN: begin
          // Counter counts NOPs already issued; the exit edge is the one
          // after the last drain NOP, so the core sees exactly
          // DRAIN_CYCLES unstalled NOP cycles.
          if (!i_cpu_stall) begin
            if (drain_cnt_q == DW'(DRAIN_CYCLES)) begin
              state_q     <= ST_DONE;
              cpu_start_q <= 1'b0;
              cpu_inst_q  <= '0;
            end else begin
              cpu_inst_q  <= NOP_INST;
              drain_cnt_q <= drain_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ecall_valid_q <= 1'b0;
      ecall_data_q  <= '0;
    end else begin
      ecall_valid_q <= i_ecall_ready;
      ecall_data_q  <= i_ecall_data;
    end
  end

  assign o_load_ready  = !fifo_full;
  assign o_cpu_start   = cpu_start_q;
  assign o_cpu_inst    = cpu_inst_q;
  assign o_issue_cnt   = issue_cnt_q;
  assign o_busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign o_done        = (state_q == ST_DONE);
  assign o_ecall_valid = ecall_valid_q;
  assign o_ecall_data  = ecall_data_q;

endmodule

// File: tb/tb_inst_issue_ctrl.sv
// Self-checking bench for inst_issue_ctrl: directed phases plus random
// programs, all compared per cycle against a queue-based reference model.
module tb_inst_issue_ctrl;

  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          DRAIN = 5;

  logic        i_clk, i_rst, i_start, i_load_valid, i_load_last, o_load_ready;
  logic [31:0] i_load_inst;
  logic        i_cpu_stall, o_cpu_start, i_ecall_ready, o_ecall_valid;
  logic [31:0] o_cpu_inst, i_ecall_data, o_ecall_data, o_issue_cnt;
  logic        o_busy, o_done;

  inst_issue_ctrl #(.DEPTH(DEPTH), .NOP_INST(NOP), .DRAIN_CYCLES(DRAIN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_load_valid(i_load_valid), .i_load_inst(i_load_inst),
    .i_load_last(i_load_last), .o_load_ready(o_load_ready),
    .i_cpu_stall(i_cpu_stall), .o_cpu_start(o_cpu_start),
    .o_cpu_inst(o_cpu_inst), .i_ecall_ready(i_ecall_ready),
    .i_ecall_data(i_ecall_data), .o_ecall_valid(o_ecall_valid),
    .o_ecall_data(o_ecall_data), .o_busy(o_busy), .o_done(o_done),
    .o_issue_cnt(o_issue_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: program queue, "running" flag, remaining drain NOPs.
  logic [32:0] m_q[$];
  bit          m_running;     // between start and completion
  int          m_nops_left;   // -1 while words are still being issued
  bit          m_finished;
  logic [31:0] m_inst, m_cnt, m_ed;
  bit          m_ev, m_acc;

  int n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_running = 0; m_nops_left = -1; m_finished = 0;
    m_inst = '0; m_cnt = '0; m_ev = 0; m_ed = '0; m_acc = 0;
  endtask

  task automatic check_all();
    chk("cpu_inst",    o_cpu_inst, m_inst);
    chk("cpu_start",   32'(o_cpu_start), 32'(m_running));
    chk("busy",        32'(o_busy), 32'(m_running));
    chk("done",        32'(o_done), 32'(m_finished));
    chk("load_ready",  32'(o_load_ready), 32'(m_q.size() < DEPTH));
    chk("issue_cnt",   o_issue_cnt, m_cnt);
    chk("ecall_valid", 32'(o_ecall_valid), 32'(m_ev));
    chk("ecall_data",  o_ecall_data, m_ed);
  endtask

  task automatic clear_inputs();
    i_start = 0; i_load_valid = 0; i_load_inst = '0; i_load_last = 0;
    i_cpu_stall = 0; i_ecall_ready = 0; i_ecall_data = '0;
  endtask

  // Apply current inputs for one edge, advance the model, then compare.
  task automatic step();
    logic [32:0] e;
    m_acc = i_load_valid && (m_q.size() < DEPTH);
    if (m_running && m_nops_left < 0) begin
      if (!i_cpu_stall) begin
        if (m_q.size() > 0) begin
          e = m_q.pop_front();
          m_inst = e[31:0];
          m_cnt  = m_cnt + 1;
          if (e[32]) m_nops_left = DRAIN;
        end else begin
          m_inst = NOP;
        end
      end
    end else if (m_running) begin
      if (!i_cpu_stall) begin
        if (m_nops_left > 0) begin
          m_inst = NOP;
          m_nops_left--;
        end else begin
          m_running = 0; m_finished = 1; m_inst = '0; m_nops_left = -1;
        end
      end
    end else if (i_start) begin
      m_running = 1; m_finished = 0; m_cnt = '0;
    end
    if (m_acc) m_q.push_back({i_load_last, i_load_inst});
    m_ev = i_ecall_ready;
    m_ed = i_ecall_data;
    @(posedge i_clk);
    #1;
    check_all();
  endtask

  task automatic push_word(input logic [31:0] w, input bit last);
    i_load_valid = 1; i_load_inst = w; i_load_last = last;
    step();
    i_load_valid = 0; i_load_last = 0;
  endtask

  task automatic pulse_start();
    i_start = 1; step(); i_start = 0;
  endtask

  // Runs until the model finishes; counts cycles showing a drain-style NOP.
  task automatic run_until_done(input int bound, output int nops);
    int n = 0;
    nops = 0;
    while (!m_finished && n < bound) begin
      step();
      if (o_busy && o_cpu_inst == NOP) nops++;
      n++;
    end
    chk("run_done", 32'(o_done), 32'd1);
  endtask

  logic [31:0] basic_w [3] = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};

  initial begin
    int nops, plen, pidx, n;
    bit kicked;
    logic [31:0] pw [32];

    n_vec = 0; n_err = 0;
    clear_inputs();
    model_reset();
    i_rst = 1;

    // Reset values
    repeat (3) begin
      @(posedge i_clk); #1;
      check_all();
    end
    i_rst = 0;
    $display("reset: checked reset outputs");

    // Basic program
    for (int i = 0; i < 3; i++) push_word(basic_w[i], i == 2);
    pulse_start();
    run_until_done(40, nops);
    chk("basic_drain_nops", nops, DRAIN);
    chk("basic_cnt", o_issue_cnt, 32'd3);
    chk("basic_inst", o_cpu_inst, 32'd0);
    $display("basic: 3 words issued, %0d drain NOPs", nops);

    // Underflow: empty FIFO, one word every 3rd cycle
    pulse_start();
    for (int c = 0; c < 12; c++) begin
      if (c % 3 == 2) push_word(32'h1000_0000 + c, c == 11);
      else step();
    end
    run_until_done(40, nops);
    chk("underflow_cnt", o_issue_cnt, 32'd4);
    $display("underflow: 4 words with gaps");

    // Stall during RUN and during DRAIN
    for (int i = 0; i < 3; i++) push_word(32'h2000_0000 + i, i == 2);
    pulse_start();
    step();
    i_cpu_stall = 1; repeat (4) step(); i_cpu_stall = 0;
    n = 0;
    while (m_nops_left != DRAIN - 2 && n < 20) begin step(); n++; end
    i_cpu_stall = 1; repeat (4) step(); i_cpu_stall = 0;
    run_until_done(40, nops);
    chk("stall_cnt", o_issue_cnt, 32'd3);
    $display("stall: 4-cycle stalls in run and drain");

    // Full FIFO: 16 accepted, 17th blocked while full even with a pop
    for (int i = 0; i < 16; i++) push_word(32'h3000_0000 + i, 0);
    chk("full_ready", 32'(o_load_ready), 32'd0);
    i_load_valid = 1; i_load_inst = 32'h3000_0010; i_load_last = 1;
    i_start = 1; step(); i_start = 0;
    n = 0;
    do begin step(); n++; end while (!m_acc && n < 6);
    i_load_valid = 0; i_load_last = 0;
    run_until_done(80, nops);
    chk("full_cnt", o_issue_cnt, 32'd17);
    $display("full: 17 words through a %0d-entry FIFO", DEPTH);

    // Ecall pulse
    i_ecall_ready = 1; i_ecall_data = 32'h0000_002A; step();
    chk("ecall_pulse", 32'(o_ecall_valid), 32'd1);
    chk("ecall_payload", o_ecall_data, 32'h0000_002A);
    i_ecall_ready = 0; i_ecall_data = 32'h0000_0055; step();
    chk("ecall_low", 32'(o_ecall_valid), 32'd0);
    $display("ecall: single pulse with payload 0x2a");

    // Reset mid-RUN
    for (int i = 0; i < 4; i++) push_word(32'h4000_0000 + i, 0);
    pulse_start();
    step(); step();
    #2 i_rst = 1;
    #1 model_reset();
    check_all();
    @(posedge i_clk); #1;
    i_rst = 0;
    check_all();
    pulse_start();
    step();
    chk("rst_fifo_empty", o_cpu_inst, NOP);
    push_word(32'h4000_00FF, 1);
    run_until_done(40, nops);
    chk("rst_cnt", o_issue_cnt, 32'd1);
    $display("reset mid-run: FIFO discarded");

    // Random programs with random stalls, loads, starts and ecalls
    for (int p = 0; p < 8; p++) begin
      plen = $urandom_range(1, 30);
      for (int i = 0; i < plen; i++) pw[i] = $urandom;
      pidx = 0; kicked = 0; n = 0;
      while (!(m_finished && kicked && pidx == plen) && n < 800) begin
        i_load_valid  = (pidx < plen) && ($urandom_range(0, 2) != 0);
        i_load_inst   = (pidx < plen) ? pw[pidx] : '0;
        i_load_last   = (pidx == plen - 1);
        i_cpu_stall   = ($urandom_range(0, 3) == 0);
        i_start       = kicked ? (m_running && $urandom_range(0, 7) == 0)
                               : ($urandom_range(0, 2) == 0);
        i_ecall_ready = $urandom_range(0, 1);
        i_ecall_data  = $urandom;
        if (i_start && !kicked) kicked = 1;
        step();
        if (m_acc) pidx++;
        n++;
      end
      clear_inputs();
      chk("rand_done", 32'(o_done), 32'd1);
      chk("rand_cnt", o_issue_cnt, plen);
      $display("random prog %0d: len=%0d cycles=%0d", p, plen, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
